// File: rtl/riscv_mem_pkg.sv
// Shared types and AMO opcode constants for the memory responder.
package riscv_mem_pkg;

  localparam logic [5:0] AtopNone = 6'h00;
  localparam logic [5:0] AtopSwap = 6'h20;
  localparam logic [5:0] AtopAdd  = 6'h21;
  localparam logic [5:0] AtopAnd  = 6'h22;
  localparam logic [5:0] AtopOr   = 6'h23;
  localparam logic [5:0] AtopXor  = 6'h24;
  localparam logic [5:0] AtopMax  = 6'h25;
  localparam logic [5:0] AtopMaxu = 6'h26;
  localparam logic [5:0] AtopMin  = 6'h27;
  localparam logic [5:0] AtopMinu = 6'h28;

  typedef enum logic { Idle, AmoWrite } state_t;
  typedef enum logic { RespReg, RespMem } resp_kind_t;

  // Unknown nonzero opcodes degrade to a plain read with no write-back.
  function automatic logic amo_has_wb(logic [5:0] op);
    return (op >= AtopSwap) && (op <= AtopMinu);
  endfunction

endpackage

// File: rtl/riscv_amo_alu.sv
// Combinational AMO datapath: new = f(old, operand).
module riscv_amo_alu
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic [5:0]           atop_i,
  input  logic [DataWidth-1:0] old_i,
  input  logic [DataWidth-1:0] operand_i,
  output logic [DataWidth-1:0] new_o
);

  logic slt, ult;
  assign slt = $signed(old_i) < $signed(operand_i);
  assign ult = old_i < operand_i;

  always_comb begin
    new_o = old_i;
    case (atop_i)
      AtopSwap: new_o = operand_i;
      AtopAdd:  new_o = old_i + operand_i;
      AtopAnd:  new_o = old_i & operand_i;
      AtopOr:   new_o = old_i | operand_i;
      AtopXor:  new_o = old_i ^ operand_i;
      AtopMax:  new_o = slt ? operand_i : old_i;
      AtopMaxu: new_o = ult ? operand_i : old_i;
      AtopMin:  new_o = slt ? old_i : operand_i;
      AtopMinu: new_o = ult ? old_i : operand_i;
      default:  new_o = old_i;
    endcase
  end

endmodule

// File: rtl/riscv_mem_responder.sv
// Request/grant/rvalid responder in front of a 1-cycle-latency SRAM, with
// blocking read-modify-write AMOs.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned MemAddrWidth = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [AddrWidth-1:0]    addr_i,
  input  logic                    we_ni,
  input  logic [DataWidth/8-1:0]  be_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [5:0]              atop_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    rvalid_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [DataWidth/8-1:0]  mem_be_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned ByteOff = $clog2(BeWidth);

  state_t                  state_q, state_d;
  logic [MemAddrWidth-1:0] amo_addr_q;
  logic [5:0]              amo_op_q;
  logic [DataWidth-1:0]    amo_operand_q;
  logic [DataWidth-1:0]    amo_new;
  logic                    rvalid_q;
  resp_kind_t              kind_q;
  logic [DataWidth-1:0]    rdata_q;
  logic [MemAddrWidth-1:0] req_addr;
  logic                    is_amo;
  logic                    unused_addr;

  assign req_addr    = addr_i[MemAddrWidth+ByteOff-1:ByteOff];
  assign unused_addr = ^addr_i;
  assign is_amo      = (atop_i != AtopNone);

  riscv_amo_alu #(.DataWidth(DataWidth)) u_alu (
    .atop_i    (amo_op_q),
    .old_i     (mem_rdata_i),
    .operand_i (amo_operand_q),
    .new_o     (amo_new)
  );

  always_comb begin
    state_d     = state_q;
    gnt_o       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = req_addr;
    mem_be_o    = be_i;
    mem_wdata_o = wdata_i;
    case (state_q)
      Idle: begin
        gnt_o     = req_i;
        mem_req_o = req_i;
        if (is_amo) begin
          mem_be_o = '1;
          if (req_i) state_d = AmoWrite;
        end else begin
          mem_we_o = ~we_ni;
        end
      end
      AmoWrite: begin
        state_d     = Idle;
        mem_req_o   = amo_has_wb(amo_op_q);
        mem_we_o    = 1'b1;
        mem_addr_o  = amo_addr_q;
        mem_be_o    = '1;
        mem_wdata_o = amo_new;
      end
      default: state_d = Idle;
    endcase
    // Reset also kills an in-flight AMO write-back.
    if (!rst_ni) begin
      gnt_o     = 1'b0;
      mem_req_o = 1'b0;
      state_d   = Idle;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= Idle;
      rvalid_q <= 1'b0;
      kind_q   <= RespReg;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= 1'b0;
      if (state_q == AmoWrite) begin
        rvalid_q <= 1'b1;
        kind_q   <= RespReg;
        rdata_q  <= mem_rdata_i;
      end else if (gnt_o && !is_amo) begin
        rvalid_q <= 1'b1;
        kind_q   <= we_ni ? RespMem : RespReg;
        rdata_q  <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == Idle && gnt_o && is_amo) begin
      amo_addr_q    <= req_addr;
      amo_op_q      <= atop_i;
      amo_operand_q <= wdata_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = (kind_q == RespMem) ? mem_rdata_i : rdata_q;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed + random bench for riscv_mem_responder against a word-array model.
module tb_riscv_mem_responder;
  localparam int AW = 16, DW = 32, MAW = 8, BW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni, we_ni, req_i, gnt_o, rvalid_o;
  logic [AW-1:0] addr_i;
  logic [BW-1:0] be_i, mem_be_o;
  logic [DW-1:0] wdata_i, rdata_o, mem_wdata_o, mem_rdata_i;
  logic [5:0]    atop_i;
  logic          mem_req_o, mem_we_o;
  logic [MAW-1:0] mem_addr_o;

  always #5 clk_i = ~clk_i;

  riscv_mem_responder #(.AddrWidth(AW), .DataWidth(DW), .MemAddrWidth(MAW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .addr_i(addr_i), .we_ni(we_ni), .be_i(be_i),
    .wdata_i(wdata_i), .atop_i(atop_i), .req_i(req_i), .gnt_o(gnt_o),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // SRAM with one-cycle read latency
  logic [DW-1:0] sram [256];
  logic [DW-1:0] rd_q;
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < BW; b++)
          if (mem_be_o[b]) sram[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      end else begin
        rd_q <= sram[mem_addr_o];
      end
    end
  end
  assign mem_rdata_i = rd_q;

  logic [DW-1:0] ref_mem [256];
  int            tests = 0, fails = 0, cyc = 0;
  int            due_q[$];
  logic [DW-1:0] data_q[$];
  bit            busy = 1'b0;

  function automatic logic [DW-1:0] amo_ref(logic [5:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    int sa, sb;
    sa = a; sb = b;
    case (op)
      6'h20: return b;
      6'h21: return a + b;
      6'h22: return a & b;
      6'h23: return a | b;
      6'h24: return a ^ b;
      6'h25: return (sa >= sb) ? a : b;
      6'h26: return (a >= b) ? a : b;
      6'h27: return (sa <= sb) ? a : b;
      6'h28: return (a <= b) ? a : b;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One cycle: check registered outputs, drive inputs, check grant, update model.
  task automatic step(input bit rst, input bit req, input bit we_n, input logic [AW-1:0] a,
                      input logic [BW-1:0] be, input logic [DW-1:0] wd, input logic [5:0] op);
    bit ev, eg;
    int w;
    logic [DW-1:0] old;
    ev = (due_q.size() > 0) && (due_q[0] == cyc);
    chk("rvalid", rvalid_o, ev);
    if (ev) begin
      chk("rdata", rdata_o, data_q[0]);
      void'(due_q.pop_front());
      void'(data_q.pop_front());
    end
    rst_ni = rst; req_i = req; we_ni = we_n; addr_i = a; be_i = be; wdata_i = wd; atop_i = op;
    #1;
    eg = rst && req && !busy;
    chk("gnt", gnt_o, eg);
    if (!rst) chk("rst_memreq", mem_req_o, 1'b0);
    w = int'(a[MAW+1:2]);
    if (!rst) begin
      due_q.delete(); data_q.delete();
    end else if (eg) begin
      if (op != 6'h00) begin
        old = ref_mem[w];
        ref_mem[w] = amo_ref(op, old, wd);
        due_q.push_back(cyc + 2); data_q.push_back(old);
      end else if (we_n) begin
        due_q.push_back(cyc + 1); data_q.push_back(ref_mem[w]);
      end else begin
        for (int b = 0; b < BW; b++) if (be[b]) ref_mem[w][b*8 +: 8] = wd[b*8 +: 8];
        due_q.push_back(cyc + 1); data_q.push_back('0);
      end
    end
    busy = eg && (op != 6'h00);
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, '0, '0, '0, 6'h00);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
    step(1'b1, 1'b1, 1'b0, a, be, d, 6'h00);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b1, 1'b1, 1'b1, a, 4'hF, '0, 6'h00);
  endtask

  task automatic amo(input logic [AW-1:0] a, input logic [5:0] op, input logic [DW-1:0] d);
    step(1'b1, 1'b1, 1'b1, a, 4'h0, d, op);
  endtask

  initial begin
    logic [DW-1:0] saved;
    int diff;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      sram[i] <= ref_mem[i];
    end
    rst_ni = 1'b0; req_i = 1'b1; we_ni = 1'b1; addr_i = '0; be_i = '0; wdata_i = '0; atop_i = '0;
    @(negedge clk_i);
    step(1'b0, 1'b1, 1'b1, 16'h0040, 4'hF, '0, 6'h00);
    step(1'b0, 1'b1, 1'b0, 16'h0044, 4'hF, 32'h1, 6'h21);
    chk("rst_rdata", rdata_o, '0);

    // write then read same address on consecutive cycles
    wr(16'h0100, 4'hF, 32'hDEADBEEF);
    rd(16'h0100);
    idle(1);
    chk("wr_rd_mem", sram[8'h40], 32'hDEADBEEF);

    // partial write
    wr(16'h0104, 4'hF, 32'hFFFFFFFF);
    wr(16'h0104, 4'b0011, 32'h00001234);
    rd(16'h0104);
    idle(1);
    chk("partial_mem", sram[8'h41], 32'hFFFF1234);

    // AMOADD wrap, req held high through T1
    wr(16'h0108, 4'hF, 32'hFFFFFFFE);
    amo(16'h0108, 6'h21, 32'd5);
    rd(16'h0108);
    rd(16'h0108);
    idle(1);
    chk("amoadd_mem", sram[8'h42], 32'h00000003);

    // signed vs unsigned max
    wr(16'h010C, 4'hF, 32'h80000000);
    wr(16'h0110, 4'hF, 32'h80000000);
    amo(16'h010C, 6'h25, 32'd1);
    idle(1);
    amo(16'h0110, 6'h26, 32'd1);
    idle(2);
    chk("amomax_mem", sram[8'h43], 32'h00000001);
    chk("amomaxu_mem", sram[8'h44], 32'h80000000);

    // unsupported opcode: read only
    amo(16'h0110, 6'h3F, 32'h12345678);
    idle(2);
    chk("badop_mem", sram[8'h44], 32'h80000000);

    // read stream with one AMO in the middle
    for (int i = 0; i < 4; i++) rd(AW'(16'h0100 + 4*i));
    amo(16'h0108, 6'h24, 32'h0F0F0F0F);
    for (int i = 0; i < 4; i++) rd(AW'(16'h0100 + 4*i));
    idle(2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(6'h1F, 6'h2A)) : 6'h00;
      step(1'b1, $urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom),
           BW'($urandom), $urandom, op);
    end
    idle(2);

    // reset during AMO write-back: no write, no response
    wr(16'h0114, 4'hF, 32'hCAFEF00D);
    idle(1);
    saved = ref_mem[8'h45];
    amo(16'h0114, 6'h20, 32'h11111111);
    step(1'b0, 1'b1, 1'b1, 16'h0114, 4'hF, '0, 6'h00);
    ref_mem[8'h45] = saved;
    chk("abort_rvalid", rvalid_o, 1'b0);
    chk("abort_rdata", rdata_o, '0);
    chk("abort_mem", sram[8'h45], 32'hCAFEF00D);
    rd(16'h0114);
    idle(2);

    chk("drain", due_q.size(), 0);
    diff = 0;
    for (int i = 0; i < 256; i++) if (sram[i] !== ref_mem[i]) diff++;
    chk("mem_image", diff, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
